pipe_enable_gen: RTL and testbench

Parametrised pipeline advance controller for the 5-stage RISC-V core. It generates registered per-stage clock enables, flush strobes and an FSM tick/toggle in three advance modes:

- free-run
- divided
- single-step

Each advance applies stall-bubble insertion and multi-cycle branch flush. It sits beside the hazard unit and drives the stage registers of IF, ID, EX, MEM and WB. Clocks are never gated; all outputs are enables.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/adv_tick_gen.sv | 45 ++++
 rtl/pipe_enable_gen.sv | 125 ++++++++++++
 tb/tb_pipe_enable_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline advance controller: FSM states, advance modes
// and a low-bit mask helper used to build the per-stage enable patterns.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_DIV  = 2'd1,
    MODE_STEP = 2'd2,
    MODE_HOLD = 2'd3
  } mode_t;

  // Mask with the n lowest bits set; saturates at 64 bits.
  function automatic logic [63:0] low_mask(input int n);
    if (n >= 64) low_mask = '1;
    else         low_mask = (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/adv_tick_gen.sv
// Advance-condition generator: mode decode, up-counting divider with >= compare,
// and rising-edge detection of the single-step request.
module adv_tick_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             step,
  output logic             adv
);

  logic [DIV_W-1:0] cnt;
  logic             step_q;
  mode_t            mode_sel;

  assign mode_sel = mode_t'(mode);

  always_comb begin
    adv = 1'b0;
    case (mode_sel)
      MODE_RUN:  adv = 1'b1;
      MODE_DIV:  adv = (cnt >= div_val);
      MODE_STEP: adv = step & ~step_q;
      default:   adv = 1'b0;
    endcase
  end

  // cnt clears on every advance, so it can never run past div_val and wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= step;
      if (!active || (mode_sel != MODE_DIV) || adv) cnt <= '0;
      else                                          cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pipe_enable_gen.sv
// Pipeline advance controller: turns the advance condition into registered
// per-stage enables and flush strobes, with stall bubbles and branch flush.
//
// state    | meaning
// ST_IDLE  | run low; no advances, counters held
// ST_RUN   | normal advancing; stall bubbles and branch acceptance
// ST_FLUSH | remaining branch-penalty advances; further branches ignored
module pipe_enable_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int STALL_STAGE = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int PENALTY     = 1,
  parameter int DIV_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [1:0]            mode,
  input  logic [DIV_W-1:0]      div_val,
  input  logic                  step,
  input  logic                  stall,
  input  logic                  branch_taken,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic                  fsm_tick,
  output logic                  fsm_toggle,
  output logic [1:0]            state
);

  localparam int PW = (PENALTY > 1) ? $clog2(PENALTY) : 1;
  localparam logic [PW-1:0] PCNT_LOAD = PW'(PENALTY - 1);
  localparam logic [NUM_STAGES-1:0] ALL_EN      = '1;
  localparam logic [NUM_STAGES-1:0] FLUSH_MASK  = NUM_STAGES'(low_mask(FLUSH_DEPTH));
  localparam logic [NUM_STAGES-1:0] STALL_EN    = ~NUM_STAGES'(low_mask(STALL_STAGE + 1));
  localparam logic [NUM_STAGES-1:0] STALL_FLUSH = NUM_STAGES'(64'd1 << (STALL_STAGE + 1));

  state_t                state_q, state_nxt;
  logic [PW-1:0]         pcnt_q, pcnt_nxt;
  logic                  toggle_nxt;
  logic [NUM_STAGES-1:0] en_nxt, flush_nxt;
  logic                  tick_nxt;
  logic                  active;
  logic                  adv;

  assign active = (state_q != ST_IDLE);
  assign state  = state_q;

  adv_tick_gen #(
    .DIV_W (DIV_W)
  ) u_adv (
    .clk     (clk),
    .reset   (reset),
    .active  (active),
    .mode    (mode),
    .div_val (div_val),
    .step    (step),
    .adv     (adv)
  );

  always_comb begin
    state_nxt  = state_q;
    pcnt_nxt   = pcnt_q;
    toggle_nxt = fsm_toggle;
    en_nxt     = '0;
    flush_nxt  = '0;
    tick_nxt   = 1'b0;
    if (!run) begin
      state_nxt = ST_IDLE;
      pcnt_nxt  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_nxt = ST_RUN;
        ST_RUN: begin
          if (adv) begin
            tick_nxt = 1'b1;
            // A branch overrides any stall in the same advance.
            if (branch_taken) begin
              toggle_nxt = ~fsm_toggle;
              en_nxt     = ALL_EN;
              flush_nxt  = FLUSH_MASK;
              pcnt_nxt   = PCNT_LOAD;
              if (PCNT_LOAD != '0) state_nxt = ST_FLUSH;
            end else if (stall) begin
              en_nxt    = STALL_EN;
              flush_nxt = STALL_FLUSH;
            end else begin
              en_nxt = ALL_EN;
            end
          end
        end
        ST_FLUSH: begin
          if (adv) begin
            tick_nxt  = 1'b1;
            en_nxt    = ALL_EN;
            flush_nxt = FLUSH_MASK;
            pcnt_nxt  = pcnt_q - PW'(1);
            if (pcnt_q == PW'(1)) state_nxt = ST_RUN;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pcnt_q      <= '0;
      fsm_toggle  <= 1'b0;
      stage_en    <= '0;
      stage_flush <= '0;
      fsm_tick    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      pcnt_q      <= pcnt_nxt;
      fsm_toggle  <= toggle_nxt;
      stage_en    <= en_nxt;
      stage_flush <= flush_nxt;
      fsm_tick    <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_enable_gen.sv
// Directed bench for pipe_enable_gen: default instance (PENALTY=1) and a
// PENALTY=3 instance share one stimulus stream.
module tb_pipe_enable_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] div_val = 8'd0;
  logic       step = 1'b0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;

  logic [4:0] en_a, fl_a, en_b, fl_b;
  logic       tick_a, tog_a, tick_b, tog_b;
  logic [1:0] st_a, st_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_enable_gen dut_a (
    .clk(clk), .reset(reset), .run(run), .mode(mode), .div_val(div_val),
    .step(step), .stall(stall), .branch_taken(branch_taken),
    .stage_en(en_a), .stage_flush(fl_a), .fsm_tick(tick_a),
    .fsm_toggle(tog_a), .state(st_a)
  );

  pipe_enable_gen #(.PENALTY(3)) dut_b (
    .clk(clk), .reset(reset), .run(run), .mode(mode), .div_val(div_val),
    .step(step), .stall(stall), .branch_taken(branch_taken),
    .stage_en(en_b), .stage_flush(fl_b), .fsm_tick(tick_b),
    .fsm_toggle(tog_b), .state(st_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b1; mode = 2'd0;
    cyc(); cyc();
    n_checks++;
    if ({en_a, fl_a, tick_a, tog_a, st_a} !== 14'd0) begin
      n_errors++;
      $display("FAIL reset_outs got en=%b fl=%b tick=%b tog=%b st=%0d exp all 0", en_a, fl_a, tick_a, tog_a, st_a);
    end
    reset = 1'b1;
    cyc();
    n_checks++;
    if (st_a !== 2'd1 || en_a !== 5'b00000 || tick_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release got st=%0d en=%b tick=%b exp st=1 en=00000 tick=0", st_a, en_a, tick_a);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (en_a !== 5'b11111 || fl_a !== 5'b00000 || tick_a !== 1'b1) begin
        n_errors++;
        $display("FAIL run_adv[%0d] got en=%b fl=%b tick=%b exp en=11111 fl=00000 tick=1", i, en_a, fl_a, tick_a);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (en_a !== 5'b11100 || fl_a !== 5'b00100 || tick_a !== 1'b1) begin
        n_errors++;
        $display("FAIL stall[%0d] got en=%b fl=%b tick=%b exp en=11100 fl=00100 tick=1", i, en_a, fl_a, tick_a);
      end
    end
    stall = 1'b0;
    cyc();
    n_checks++;
    if (en_a !== 5'b11111 || fl_a !== 5'b00000) begin
      n_errors++;
      $display("FAIL stall_release got en=%b fl=%b exp en=11111 fl=00000", en_a, fl_a);
    end
  endtask

  task automatic test_branch();
    stall = 1'b1; branch_taken = 1'b1;
    cyc();
    n_checks++;
    if (en_a !== 5'b11111 || fl_a !== 5'b00011 || tog_a !== 1'b1 || st_a !== 2'd1) begin
      n_errors++;
      $display("FAIL branch_p1 got en=%b fl=%b tog=%b st=%0d exp 11111 00011 1 1", en_a, fl_a, tog_a, st_a);
    end
    n_checks++;
    if (en_b !== 5'b11111 || fl_b !== 5'b00011 || tog_b !== 1'b1 || st_b !== 2'd2) begin
      n_errors++;
      $display("FAIL branch_p3_first got en=%b fl=%b tog=%b st=%0d exp 11111 00011 1 2", en_b, fl_b, tog_b, st_b);
    end
    stall = 1'b0;
    cyc();
    n_checks++;
    if (fl_b !== 5'b00011 || tog_b !== 1'b1 || st_b !== 2'd2) begin
      n_errors++;
      $display("FAIL branch_p3_second got fl=%b tog=%b st=%0d exp 00011 1 2", fl_b, tog_b, st_b);
    end
    n_checks++;
    if (fl_a !== 5'b00011 || tog_a !== 1'b0) begin
      n_errors++;
      $display("FAIL branch_p1_again got fl=%b tog=%b exp 00011 0", fl_a, tog_a);
    end
    branch_taken = 1'b0;
    cyc();
    n_checks++;
    if (fl_b !== 5'b00011 || en_b !== 5'b11111 || tog_b !== 1'b1 || st_b !== 2'd1) begin
      n_errors++;
      $display("FAIL branch_p3_third got fl=%b en=%b tog=%b st=%0d exp 00011 11111 1 1", fl_b, en_b, tog_b, st_b);
    end
    n_checks++;
    if (fl_a !== 5'b00000 || en_a !== 5'b11111) begin
      n_errors++;
      $display("FAIL branch_p1_after got fl=%b en=%b exp 00000 11111", fl_a, en_a);
    end
    cyc();
    n_checks++;
    if (fl_b !== 5'b00000 || en_b !== 5'b11111) begin
      n_errors++;
      $display("FAIL branch_p3_after got fl=%b en=%b exp 00000 11111", fl_b, en_b);
    end
  endtask

  task automatic test_div();
    logic       exp_t;
    logic [4:0] exp_en;
    logic       exp_seq [4];
    mode = 2'd1; div_val = 8'd3;
    for (int i = 0; i < 8; i++) begin
      cyc();
      exp_t  = ((i % 4) == 3);
      exp_en = exp_t ? 5'b11111 : 5'b00000;
      n_checks++;
      if (tick_a !== exp_t || en_a !== exp_en) begin
        n_errors++;
        $display("FAIL div3[%0d] got tick=%b en=%b exp tick=%b en=%b", i, tick_a, en_a, exp_t, exp_en);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if (tick_a !== 1'b0) begin
        n_errors++;
        $display("FAIL div3_pre[%0d] got tick=%b exp 0", i, tick_a);
      end
    end
    div_val = 8'd1;
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if (tick_a !== exp_seq[i]) begin
        n_errors++;
        $display("FAIL div_lower[%0d] got tick=%b exp %b", i, tick_a, exp_seq[i]);
      end
    end
    div_val = 8'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (tick_a !== 1'b1 || en_a !== 5'b11111) begin
        n_errors++;
        $display("FAIL div0[%0d] got tick=%b en=%b exp 1 11111", i, tick_a, en_a);
      end
    end
  endtask

  task automatic test_step();
    int ticks = 0;
    logic exp_t;
    mode = 2'd2; step = 1'b0;
    cyc();
    n_checks++;
    if (tick_a !== 1'b0) begin
      n_errors++;
      $display("FAIL step_idle got tick=%b exp 0", tick_a);
    end
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      exp_t = (i == 0);
      ticks += int'(tick_a);
      n_checks++;
      if (tick_a !== exp_t) begin
        n_errors++;
        $display("FAIL step_held[%0d] got tick=%b exp %b", i, tick_a, exp_t);
      end
    end
    step = 1'b0;
    cyc(); ticks += int'(tick_a);
    cyc(); ticks += int'(tick_a);
    step = 1'b1;
    cyc(); ticks += int'(tick_a);
    n_checks++;
    if (tick_a !== 1'b1 || en_a !== 5'b11111) begin
      n_errors++;
      $display("FAIL step_pulse got tick=%b en=%b exp 1 11111", tick_a, en_a);
    end
    step = 1'b0;
    cyc(); ticks += int'(tick_a);
    n_checks++;
    if (ticks != 2) begin
      n_errors++;
      $display("FAIL step_count got %0d exp 2", ticks);
    end
  endtask

  task automatic test_run_drop();
    mode = 2'd0;
    cyc();
    branch_taken = 1'b1;
    cyc();
    n_checks++;
    if (st_b !== 2'd2) begin
      n_errors++;
      $display("FAIL drop_pre got st=%0d exp 2", st_b);
    end
    branch_taken = 1'b0; run = 1'b0;
    cyc();
    n_checks++;
    if (st_b !== 2'd0 || en_b !== 5'b00000 || tick_b !== 1'b0 || st_a !== 2'd0) begin
      n_errors++;
      $display("FAIL drop_idle got st_b=%0d en=%b tick=%b st_a=%0d exp 0 00000 0 0", st_b, en_b, tick_b, st_a);
    end
    run = 1'b1;
    cyc();
    n_checks++;
    if (st_b !== 2'd1 || en_b !== 5'b00000) begin
      n_errors++;
      $display("FAIL drop_rerun got st=%0d en=%b exp 1 00000", st_b, en_b);
    end
    cyc();
    n_checks++;
    if (en_b !== 5'b11111 || fl_b !== 5'b00000) begin
      n_errors++;
      $display("FAIL drop_discard got en=%b fl=%b exp 11111 00000", en_b, fl_b);
    end
  endtask

  task automatic test_reset_mid_flush();
    branch_taken = 1'b1;
    cyc();
    n_checks++;
    if (st_b !== 2'd2 || tog_b !== 1'b1 || fl_b !== 5'b00011) begin
      n_errors++;
      $display("FAIL midflush_pre got st=%0d tog=%b fl=%b exp 2 1 00011", st_b, tog_b, fl_b);
    end
    branch_taken = 1'b0; reset = 1'b0;
    cyc();
    n_checks++;
    if (st_b !== 2'd0 || fl_b !== 5'b00000 || tog_b !== 1'b0 || en_b !== 5'b00000) begin
      n_errors++;
      $display("FAIL midflush_reset got st=%0d fl=%b tog=%b en=%b exp 0 00000 0 00000", st_b, fl_b, tog_b, en_b);
    end
    reset = 1'b1;
    cyc(); cyc();
    n_checks++;
    if (en_b !== 5'b11111 || fl_b !== 5'b00000 || st_b !== 2'd1) begin
      n_errors++;
      $display("FAIL midflush_resume got en=%b fl=%b st=%0d exp 11111 00000 1", en_b, fl_b, st_b);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_div();
    test_step();
    test_run_drop();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
